// File: rtl/conv_mac_accum.sv
// rtl/conv_mac_accum.sv - Paired-pixel convolution MAC with windowed accumulate, ReLU and saturation
module conv_mac_accum #(
  parameter int KERNEL_WIDTH      = 5,
  parameter int INFEA_ONEMEM      = 1,
  parameter int INPUT_NUM_MEM     = 1,
  parameter int OUT_FEATURE_WIDTH = 32,
  parameter int NUM_ONEMULT       = 1,
  parameter int DATA_WIDTH        = 16,
  parameter int WEIGHT_WIDTH      = 16,
  parameter int ACC_WIDTH         = 40,
  parameter int OUT_DATA_WIDTH    = 16,
  parameter int FRAC_SHIFT        = 8,
  parameter int OUT_ADDR_WIDTH    = 11
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  input  logic [DATA_WIDTH-1:0]     douta,
  input  logic [DATA_WIDTH-1:0]     doutb,
  input  logic [WEIGHT_WIDTH-1:0]   weight_a,
  input  logic [WEIGHT_WIDTH-1:0]   weight_b,
  output logic                      out_valid,
  output logic [OUT_DATA_WIDTH-1:0] out_data,
  output logic [OUT_ADDR_WIDTH-1:0] out_addr,
  output logic                      done,
  output logic                      overrun
);

  localparam int PAIRS  = (KERNEL_WIDTH * KERNEL_WIDTH + 1) / 2;
  localparam int BEATS  = PAIRS * INFEA_ONEMEM * INPUT_NUM_MEM;
  localparam int TOTAL  = OUT_FEATURE_WIDTH * OUT_FEATURE_WIDTH * NUM_ONEMULT;
  localparam bit KK_ODD = ((KERNEL_WIDTH * KERNEL_WIDTH) % 2) == 1;
  localparam int PAIR_W = $clog2(PAIRS + 1);
  localparam int BEAT_W = $clog2(BEATS + 1);
  localparam int RES_W  = $clog2(TOTAL + 1);
  localparam int PROD_W = DATA_WIDTH + WEIGHT_WIDTH;
  localparam logic signed [ACC_WIDTH-1:0] OUT_MAX =
    {{(ACC_WIDTH - OUT_DATA_WIDTH + 1){1'b0}}, {(OUT_DATA_WIDTH - 1){1'b1}}};

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t                       state_q, state_d;
  logic                         accept;
  logic [PAIR_W-1:0]            pair_cnt;
  logic [BEAT_W-1:0]            beat_cnt;
  logic [RES_W-1:0]             res_cnt;
  logic                         mask_b;
  logic signed [PROD_W-1:0]     prod_a, prod_b;
  logic signed [ACC_WIDTH-1:0]  term_a, term_b, beat_sum;
  logic                         s1_valid, s1_first, s1_last;
  logic signed [ACC_WIDTH-1:0]  s1_sum, acc, final_sum, shifted;
  logic [OUT_DATA_WIDTH-1:0]    result;

  assign accept = in_valid && (state_q != DONE);

  // An odd K*K leaves the B half of each group's last pair empty.
  assign mask_b   = KK_ODD && (pair_cnt == PAIR_W'(PAIRS - 1));
  assign prod_a   = $signed(douta) * $signed(weight_a);
  assign prod_b   = $signed(doutb) * $signed(weight_b);
  assign term_a   = {{(ACC_WIDTH - PROD_W){prod_a[PROD_W-1]}}, prod_a};
  assign term_b   = mask_b ? '0 : {{(ACC_WIDTH - PROD_W){prod_b[PROD_W-1]}}, prod_b};
  assign beat_sum = term_a + term_b;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pair_cnt <= '0;
      beat_cnt <= '0;
    end else if (accept) begin
      pair_cnt <= (pair_cnt == PAIR_W'(PAIRS - 1)) ? '0 : pair_cnt + 1'b1;
      beat_cnt <= (beat_cnt == BEAT_W'(BEATS - 1)) ? '0 : beat_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid <= 1'b0;
      s1_first <= 1'b0;
      s1_last  <= 1'b0;
      s1_sum   <= '0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_sum   <= beat_sum;
        s1_first <= (beat_cnt == '0);
        s1_last  <= (beat_cnt == BEAT_W'(BEATS - 1));
      end
    end
  end

  // The first beat of a window reloads, so back-to-back windows need no clear cycle.
  assign final_sum = s1_first ? s1_sum : acc + s1_sum;
  assign shifted   = final_sum >>> FRAC_SHIFT;

  always_comb begin
    result = shifted[OUT_DATA_WIDTH-1:0];
    if (shifted[ACC_WIDTH-1]) begin
      result = '0;
    end else if (shifted > OUT_MAX) begin
      result = OUT_MAX[OUT_DATA_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_addr  <= '0;
      res_cnt   <= '0;
    end else begin
      if (s1_valid) begin
        acc <= final_sum;
      end
      out_valid <= s1_valid && s1_last;
      if (s1_valid && s1_last) begin
        out_data <= result;
      end
      if (out_valid) begin
        out_addr <= out_addr + 1'b1;
        res_cnt  <= res_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      overrun <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == DONE && in_valid) begin
        overrun <= 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    done    = (state_q == DONE);
    case (state_q)
      IDLE:    if (in_valid) state_d = ACCUM;
      ACCUM:   if (out_valid && res_cnt == RES_W'(TOTAL - 1)) state_d = DONE;
      DONE:    state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_conv_mac_accum.sv
// tb/tb_conv_mac_accum.sv - Scoreboard bench for conv_mac_accum (K=3, 2x2 output map)
module tb_conv_mac_accum;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] douta = '0, doutb = '0, weight_a = '0, weight_b = '0;
  logic        out_valid;
  logic [15:0] out_data;
  logic [10:0] out_addr;
  logic        done, overrun;

  conv_mac_accum #(
    .KERNEL_WIDTH(3), .INFEA_ONEMEM(1), .INPUT_NUM_MEM(1), .OUT_FEATURE_WIDTH(2),
    .NUM_ONEMULT(1), .DATA_WIDTH(16), .WEIGHT_WIDTH(16), .ACC_WIDTH(40),
    .OUT_DATA_WIDTH(16), .FRAC_SHIFT(0), .OUT_ADDR_WIDTH(11)
  ) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid),
    .douta(douta), .doutb(doutb), .weight_a(weight_a), .weight_b(weight_b),
    .out_valid(out_valid), .out_data(out_data), .out_addr(out_addr),
    .done(done), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] data;
    logic [10:0] addr;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass = 0;
  int   exp_addr = 0;

  task automatic check(input string name, input longint act, input longint expv);
    n_checks++;
    if (act == expv) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, expv);
  endtask

  // Monitor: every out_valid cycle must match the oldest pending expectation.
  always @(negedge clk) begin
    if (reset && out_valid) begin
      if (sb.size() == 0) begin
        check("unexpected_out_valid", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("out_data", out_data, e.data);
        check("out_addr", out_addr, e.addr);
        check("out_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic apply_reset(input bit chk);
    #2 reset = 1'b0;
    #1;
    sb.delete();
    exp_addr = 0;
    if (chk) begin
      check("rst_out_valid", out_valid, 0);
      check("rst_out_data", out_data, 0);
      check("rst_out_addr", out_addr, 0);
      check("rst_done", done, 0);
      check("rst_overrun", overrun, 0);
    end
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Presents one beat for a cycle; caller sits at posedge+1.
  task automatic beat(input logic [15:0] px, input logic [15:0] wt);
    in_valid = 1'b1;
    douta = px; doutb = px; weight_a = wt; weight_b = wt;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic window(input logic [15:0] px, input logic [15:0] wt, input bit gap,
                        input logic [15:0] expv);
    for (int i = 0; i < 5; i++) begin
      if (i == 4) begin
        sb.push_back('{expv, 11'(exp_addr), cyc + 2});
        exp_addr++;
      end
      beat(px, wt);
      if (gap) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic drain();
    int waited = 0;
    while (sb.size() != 0 && waited < 20) begin
      @(posedge clk);
      #1;
      waited++;
    end
    check("drain_empty", sb.size(), 0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Consecutive beats of ones: 5 pairs, last B masked -> 9
    apply_reset(1'b1);
    window(16'd1, 16'd1, 1'b0, 16'd9);
    drain();

    // Same window with bubbles between valid beats
    apply_reset(1'b0);
    window(16'd1, 16'd1, 1'b1, 16'd9);
    drain();

    // Back-to-back windows: 9 then 18 at addresses 0 and 1
    apply_reset(1'b0);
    window(16'd1, 16'd1, 1'b0, 16'd9);
    window(16'd2, 16'd1, 1'b0, 16'd18);
    drain();

    // Negative result clamps to 0; large positive saturates to 32767
    apply_reset(1'b0);
    window(16'd1, 16'hFFFF, 1'b0, 16'd0);
    window(16'd32767, 16'd32767, 1'b0, 16'd32767);
    drain();

    // Partial window discarded by reset
    apply_reset(1'b0);
    for (int i = 0; i < 3; i++) beat(16'd1, 16'd1);
    apply_reset(1'b0);
    window(16'd1, 16'd1, 1'b0, 16'd9);
    drain();

    // Four results complete the map; later beats only raise overrun
    apply_reset(1'b0);
    window(16'd1, 16'd1, 1'b0, 16'd9);
    window(16'd2, 16'd1, 1'b0, 16'd18);
    window(16'd3, 16'd1, 1'b0, 16'd27);
    check("done_before_last", done, 0);
    window(16'd1, 16'd3, 1'b0, 16'd27);
    drain();
    check("done_after_last", done, 1);
    check("overrun_before_extra", overrun, 0);
    for (int i = 0; i < 5; i++) beat(16'd1, 16'd1);
    repeat (4) @(posedge clk);
    #1;
    check("overrun_after_extra", overrun, 1);
    check("done_stays", done, 1);
    check("out_addr_final", out_addr, 4);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
